imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the decode stage. Extracts
//  and sign/zero-extends the immediate for the selected format to XLEN bits,

---
 rtl/imm_gen_pipe.sv | 111 +++++++++++
 tb/tb_imm_gen_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extracts and extends the immediate for the
// selected format, then carries it through STAGES stall/flush-aware registers.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_in,
  input  logic [2:0]      imm_sel_in,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_sel_out,
  output logic            valid_out,
  output logic            sel_err_out
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $fatal(1, "imm_gen_pipe: STAGES must be in 1..4");
  end

  typedef enum logic [2:0] {
    SEL_I     = 3'b000,
    SEL_S     = 3'b001,
    SEL_B     = 3'b010,
    SEL_U     = 3'b011,
    SEL_J     = 3'b100,
    SEL_SHAMT = 3'b101,
    SEL_ZIMM  = 3'b110,
    SEL_BAD   = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic            valid;
    logic [2:0]      sel;
    logic            err;
    logic [XLEN-1:0] imm;
  } stage_t;

  logic [31:0]     imm32;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;
  stage_t          entry_d;
  stage_t          stage_q [STAGES];

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_in[6:0];

  // Signed formats are first assembled as 32-bit values and then widened, so
  // the sign bit (always instr_in[31]) replicates across any XLEN.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    imm32   = '0;
    ext_imm = '0;
    ext_err = 1'b0;
    unique case (imm_sel_e'(imm_sel_in))
      SEL_I: imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      SEL_S: imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      SEL_B: imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                      instr_in[30:25], instr_in[11:8], 1'b0};
      SEL_U: imm32 = {instr_in[31:12], 12'b0};
      SEL_J: imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                      instr_in[20], instr_in[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    unique case (imm_sel_e'(imm_sel_in))
      SEL_SHAMT: ext_imm = (XLEN == 32) ? XLEN'(instr_in[24:20])
                                        : XLEN'(instr_in[25:20]);
      SEL_ZIMM:  ext_imm = XLEN'(instr_in[19:15]);
      SEL_BAD:   ext_err = 1'b1;
      default:   ext_imm = XLEN'($signed(imm32));
    endcase
  end

  // A bubble carries all-zero fields so idle stages never show stale data.
  always_comb begin
    entry_d = '0;
    if (valid_in) begin
      entry_d.valid = 1'b1;
      entry_d.sel   = imm_sel_in;
      entry_d.err   = ext_err;
      entry_d.imm   = ext_imm;
    end
  end

  // NOTE: the stage array is few and narrow, so every entry is reset and
  // flushed explicitly; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (!stall) begin
      stage_q[0] <= entry_d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign imm_out     = stage_q[STAGES-1].imm;
  assign imm_sel_out = stage_q[STAGES-1].sel;
  assign valid_out   = stage_q[STAGES-1].valid;
  assign sel_err_out = stage_q[STAGES-1].err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three configurations share one input
// stream and are checked every cycle against a history-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [2:0]  imm_sel_in;
  logic        valid_in, stall, flush;

  logic [31:0] a_imm;  logic [2:0] a_sel;  logic a_valid, a_err;
  logic [63:0] b_imm;  logic [2:0] b_sel;  logic b_valid, b_err;
  logic [31:0] c_imm;  logic [2:0] c_sel;  logic c_valid, c_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imm_sel_in(imm_sel_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .imm_out(a_imm), .imm_sel_out(a_sel), .valid_out(a_valid), .sel_err_out(a_err));

  imm_gen_pipe #(.XLEN(64), .STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imm_sel_in(imm_sel_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .imm_out(b_imm), .imm_sel_out(b_sel), .valid_out(b_valid), .sel_err_out(b_err));

  imm_gen_pipe #(.XLEN(32), .STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imm_sel_in(imm_sel_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .imm_out(c_imm), .imm_sel_out(c_sel), .valid_out(c_valid), .sel_err_out(c_err));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the accepted input stream, one record per advancing edge.
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic        valid;
  } rec_t;

  rec_t hist[$];

  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s,
                                          input int xlen);
    longint sx, r;
    sx = longint'($signed(i));
    case (s)
      3'd0: r = sx >>> 20;
      3'd1: r = ((sx >>> 25) << 5) | longint'(i[11:7]);
      3'd2: r = ((sx >>> 31) << 12) | (longint'(i[7]) << 11)
              | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      3'd3: r = (sx >>> 12) << 12;
      3'd4: r = ((sx >>> 31) << 20) | (longint'(i[19:12]) << 12)
              | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      3'd5: r = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
      3'd6: r = longint'(i[19:15]);
      default: r = 0;
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  // The output of a STAGES-deep pipe is the record accepted STAGES advances ago.
  task automatic expected(input int stages, input int xlen, output logic [63:0] imm,
                          output logic [2:0] sel, output logic v, output logic e);
    rec_t r;
    r = '{instr: '0, sel: '0, valid: 1'b0};
    if (hist.size() >= stages) r = hist[hist.size() - stages];
    v   = r.valid;
    sel = r.valid ? r.sel : 3'd0;
    e   = r.valid && (r.sel == 3'd7);
    imm = r.valid ? ref_imm(r.instr, r.sel, xlen) : 64'd0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      hist.delete();
    end else if (!stall) begin
      hist.push_back('{instr: valid_in ? instr_in : 32'd0,
                       sel: valid_in ? imm_sel_in : 3'd0, valid: valid_in});
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [63:0] ei;
    logic [2:0]  es;
    logic        ev, ee;
    expected(1, 32, ei, es, ev, ee);
    check("A.imm", 64'(a_imm), ei);  check("A.sel", 64'(a_sel), 64'(es));
    check("A.valid", 64'(a_valid), 64'(ev));  check("A.err", 64'(a_err), 64'(ee));
    expected(3, 64, ei, es, ev, ee);
    check("B.imm", b_imm, ei);  check("B.sel", 64'(b_sel), 64'(es));
    check("B.valid", 64'(b_valid), 64'(ev));  check("B.err", 64'(b_err), 64'(ee));
    expected(2, 32, ei, es, ev, ee);
    check("C.imm", 64'(c_imm), ei);  check("C.sel", 64'(c_sel), 64'(es));
    check("C.valid", 64'(c_valid), 64'(ev));  check("C.err", 64'(c_err), 64'(ee));
  end

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic step(input logic [31:0] i, input logic [2:0] s, input logic v,
                      input logic st = 1'b0, input logic fl = 1'b0);
    instr_in   = i;
    imm_sel_in = s;
    valid_in   = v;
    stall      = st;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".A_out"}, {a_imm, 1'b0, a_sel, 2'b0, a_valid, a_err}, 64'd0);
    check({tag, ".B_imm"}, b_imm, 64'd0);
    check({tag, ".B_ctl"}, {59'd0, b_sel, b_valid, b_err}, 64'd0);
    check({tag, ".C_out"}, {c_imm, 1'b0, c_sel, 2'b0, c_valid, c_err}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_in = '0; imm_sel_in = '0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single-stage formats, then the 64-bit three-stage view of the same stream.
    step(32'hFFF00093, 3'd0, 1'b1);
    check("T1.a_imm", 64'(a_imm), 64'hFFFF_FFFF);
    check("T1.a_valid", 64'(a_valid), 64'd1);
    step(32'hFE000EE3, 3'd2, 1'b1);
    check("T2.b_type", 64'(a_imm), 64'hFFFF_FFFC);
    step(32'h0000006F, 3'd4, 1'b1);
    check("T2.j_type", 64'(a_imm), 64'd0);
    step(32'h800000B7, 3'd3, 1'b1);
    check("T3.u_type32", 64'(a_imm), 64'h8000_0000);
    step(32'h03F09093, 3'd5, 1'b1);
    check("T3.shamt32", 64'(a_imm), 64'h1F);
    step(32'h000FD073, 3'd6, 1'b1);
    check("zimm", 64'(a_imm), 64'h1F);
    check("T3.u_type64", b_imm, 64'hFFFF_FFFF_8000_0000);
    step(32'hFE112E23, 3'd1, 1'b1);
    check("s_type", 64'(a_imm), 64'hFFFF_FFFC);
    check("T3.shamt64", b_imm, 64'h3F);

    // Two stall cycles with junk input: everything holds.
    step(32'hDEADBEEF, 3'd0, 1'b1, 1'b1);
    check("T4.stall1", b_imm, 64'h3F);
    step(32'hDEADBEEF, 3'd0, 1'b1, 1'b1);
    check("T4.stall2", b_imm, 64'h3F);
    check("T4.stall_a", 64'(a_imm), 64'hFFFF_FFFC);
    step(32'h0, 3'd0, 1'b0);
    check("T4.zimm64", b_imm, 64'h1F);
    step(32'h0, 3'd0, 1'b0);
    check("T4.s64", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("T4.s64_sel", 64'(b_sel), 64'd1);
    step(32'h0, 3'd0, 1'b0);
    check("T4.drain", 64'(b_valid), 64'd0);

    // Flush together with stall while two entries are in flight in C.
    step(32'hFFF00093, 3'd0, 1'b1);
    step(32'hFE112E23, 3'd1, 1'b1);
    check("T5.pre_flush", 64'(c_valid), 64'd1);
    step(32'h12345678, 3'd0, 1'b1, 1'b1, 1'b1);
    check("T5.flush_v1", {c_imm, 31'd0, c_valid}, 64'd0);
    step(32'h0, 3'd0, 1'b0);
    check("T5.flush_v2", {c_imm, 31'd0, c_valid}, 64'd0);
    step(32'hFFFFFFFF, 3'd7, 1'b1);
    check("T5.err_a", {a_imm, 28'd0, a_sel, a_err}, {32'd0, 28'd0, 3'd7, 1'b1});
    step(32'h0, 3'd0, 1'b0);
    check("T5.err_c", {c_imm, 27'd0, c_sel, c_valid, c_err}, {32'd0, 27'd0, 3'd7, 2'b11});

    // Asynchronous reset mid-cycle while outputs are valid.
    step(32'hFFF00093, 3'd0, 1'b1);
    step(32'h800000B7, 3'd3, 1'b1);
    step(32'h03F09093, 3'd5, 1'b1);
    check("T6.pre_a", 64'(a_valid), 64'd1);
    check("T6.pre_b", 64'(b_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("T6.async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(32'h800000B7, 3'd3, 1'b1);
    check("T6.refill_a", 64'(a_imm), 64'h8000_0000);
    check("T6.refill_b_empty", 64'(b_valid), 64'd0);
    step(32'h0, 3'd0, 1'b0);
    step(32'h0, 3'd0, 1'b0);
    check("T6.refill_b", b_imm, 64'hFFFF_FFFF_8000_0000);

    // Mixed stream: every selector, bubbles, stalls and one flush.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      w = 32'h9E3779B9 * (i + 1);
      step(w, 3'(i), (i % 7) != 3, (i % 6) == 4, i == 20);
    end
    repeat (4) step(32'h0, 3'd0, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
